// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: play modes, FSM states and
// pointer direction encoding.
package led_seq_pkg;

    typedef enum logic [1:0] {
        LOOP     = 2'b00,
        ONESHOT  = 2'b01,
        PINGPONG = 2'b10,
        HOLD     = 2'b11
    } mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/led_seq_if.sv
// Host-side bus of the LED pattern sequencer: table write port, play window
// and mode controls, and the LED/status outputs.
// Optional: LED_SEQ_PWM_EN adds the 4-bit brightness control.
interface led_seq_if #(
    parameter int LEDS_NR = 8,
    parameter int AW      = 4
);
    import led_seq_pkg::*;

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [LEDS_NR-1:0] wr_data;
    logic [AW-1:0]      start_addr;
    logic [AW-1:0]      end_addr;
    mode_t              mode;
    logic               pause;
    logic               restart;
`ifdef LED_SEQ_PWM_EN
    logic [3:0]         brightness;
`endif
    logic [LEDS_NR-1:0] led;
    logic               step;
    logic [AW-1:0]      pc;
    logic               done;

`ifdef LED_SEQ_PWM_EN
    modport master (
        output wr_en, wr_addr, wr_data, start_addr, end_addr, mode, pause, restart, brightness,
        input  led, step, pc, done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start_addr, end_addr, mode, pause, restart, brightness,
        output led, step, pc, done
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, start_addr, end_addr, mode, pause, restart,
        input  led, step, pc, done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start_addr, end_addr, mode, pause, restart,
        output led, step, pc, done
    );
`endif

endinterface

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: down-counter that pulses step for one cycle on expiry
// and reloads PRESC-1. Pause freezes the count; reload restarts a full period.
module led_seq_prescaler #(
    parameter int PRESC = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic pause,
    input  logic reload,
    output logic step
);
    localparam int            CW  = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CW-1:0] TOP = CW'(PRESC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry detection and next count
    always_comb begin
        step  = (cnt_q == '0) && !pause;
        cnt_d = cnt_q;
        if (reload)
            cnt_d = TOP;
        else if (!pause)
            cnt_d = (cnt_q == '0) ? TOP : cnt_q - CW'(1);
    end

    // Count register
    always_ff @(posedge clk) begin
        if (resetn) cnt_q <= TOP;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern player: writable LUT-RAM pattern table, play-pointer FSM with
// loop/one-shot/ping-pong/hold modes, and a registered LED output stage.
// Optional: LED_SEQ_PWM_EN adds brightness gating through a free-running
// 4-bit PWM counter.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int LEDS_NR        = 8,
    parameter int DEPTH          = 16,
    parameter int CLK_HZ         = 24_000_000,
    parameter int STEP_HZ        = 1,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic     clk,
    input  logic     resetn,
    led_seq_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PRESC = CLK_HZ / STEP_HZ;
    localparam logic [LEDS_NR-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? {LEDS_NR{1'b1}} : '0;

    logic [LEDS_NR-1:0] mem_q [DEPTH];
    logic               step;
    state_t             state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [LEDS_NR-1:0] led_q, led_d;
    logic [LEDS_NR-1:0] pat;
    logic               lit;
    logic               win_bad, pc_out;

    // Pattern table write port; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    end

    led_seq_prescaler #(.PRESC(PRESC)) u_presc (
        .clk    (clk),
        .resetn (resetn),
        .pause  (bus.pause),
        .reload (bus.restart),
        .step   (step)
    );

    assign win_bad = bus.start_addr > bus.end_addr;
    assign pc_out  = (pc_q < bus.start_addr) || (pc_q > bus.end_addr);

    // Next pointer/direction/state; restart outranks a step advance
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pc_d    = pc_q;
        if (bus.restart) begin
            pc_d    = bus.start_addr;
            dir_d   = DIR_UP;
            state_d = RUN;
        end else if (step && state_q == RUN) begin
            if (win_bad || pc_out) begin
                pc_d = bus.start_addr;
            end else begin
                case (bus.mode)
                    LOOP:
                        pc_d = (pc_q == bus.end_addr) ? bus.start_addr : pc_q + AW'(1);
                    ONESHOT:
                        if (pc_q == bus.end_addr) state_d = DONE;
                        else                      pc_d    = pc_q + AW'(1);
                    PINGPONG:
                        if (dir_q == DIR_UP) begin
                            if (pc_q == bus.end_addr) begin
                                dir_d = DIR_DOWN;
                                // single-entry window: bounce in place
                                if (bus.start_addr != bus.end_addr) pc_d = pc_q - AW'(1);
                            end else begin
                                pc_d = pc_q + AW'(1);
                            end
                        end else begin
                            if (pc_q == bus.start_addr) begin
                                dir_d = DIR_UP;
                                if (bus.start_addr != bus.end_addr) pc_d = pc_q + AW'(1);
                            end else begin
                                pc_d = pc_q - AW'(1);
                            end
                        end
                    default: ;
                endcase
            end
        end
    end

    // FSM, direction and pointer registers
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= RUN;
            dir_q   <= DIR_UP;
            pc_q    <= bus.start_addr;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pc_q    <= pc_d;
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_cnt_q;

    // Free-running PWM phase counter
    always_ff @(posedge clk) begin
        if (resetn) pwm_cnt_q <= '0;
        else        pwm_cnt_q <= pwm_cnt_q + 4'd1;
    end

    assign lit = (bus.brightness == 4'hF) || (pwm_cnt_q < bus.brightness);
`else
    assign lit = 1'b1;
`endif

    // Gate before polarity so brightness dims lit bits in either polarity
    always_comb begin
        pat   = mem_q[pc_q] & {LEDS_NR{lit}};
        led_d = (LED_ACTIVE_LOW != 0) ? ~pat : pat;
    end

    // Registered LED drive; a write to the shown entry appears one cycle later
    always_ff @(posedge clk) begin
        if (resetn) led_q <= LED_OFF;
        else        led_q <= led_d;
    end

    assign bus.led  = led_q;
    assign bus.step = step;
    assign bus.pc   = pc_q;
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a pc/done/led scoreboard.
module tb_led_pattern_sequencer;
    import led_seq_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_seq_if #(.LEDS_NR(8), .AW(4)) sif ();

    led_pattern_sequencer #(
        .LEDS_NR(8), .DEPTH(16), .CLK_HZ(8), .STEP_HZ(1), .LED_ACTIVE_LOW(1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sif)
    );

    typedef struct {
        logic [3:0] pc;
        logic       done;
        logic [7:0] led;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [16];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] p, input logic d);
        exp_t e;
        e.pc   = p;
        e.done = d;
        e.led  = ~mdl[p];
        sb.push_back(e);
    endtask

    // Wait (bounded) for a step pulse, then move past the edge it acts on
    task automatic wait_step(output int at);
        int n = 0;
        while (sif.step !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (sif.step === 1'b1) else begin
            bad++;
            $error("FAIL step_timeout observed=%0b expected=1", sif.step);
        end
        at = cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_sb(input string tag);
        exp_t e;
        int   prev = 0;
        int   at;
        bit   first = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_step(at);
            if (!first) chk($sformatf("%s_iv", tag), at - prev, 8);
            prev  = at;
            first = 1'b0;
            chk($sformatf("%s_pc", tag), sif.pc, e.pc);
            chk($sformatf("%s_done", tag), sif.done, e.done);
            @(negedge clk);
            chk($sformatf("%s_led", tag), sif.led, e.led);
        end
    endtask

    task automatic restart_pulse;
        sif.restart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.restart = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, rel, nsteps;
        sif.wr_en      = 1'b0;
        sif.wr_addr    = '0;
        sif.wr_data    = '0;
        sif.start_addr = 4'd2;
        sif.end_addr   = 4'd4;
        sif.mode       = LOOP;
        sif.pause      = 1'b0;
        sif.restart    = 1'b0;
`ifdef LED_SEQ_PWM_EN
        sif.brightness = 4'hF;
`endif
        resetn = 1'b1;

        // load table while still in reset
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            sif.wr_en   = 1'b1;
            sif.wr_addr = 4'(i);
            sif.wr_data = 8'(i + 1);
            mdl[i]      = 8'(i + 1);
            @(negedge clk);
        end
        sif.wr_en = 1'b0;

        chk("rst_pc",   sif.pc,   4'd2);
        chk("rst_done", sif.done, 1'b0);
        chk("rst_step", sif.step, 1'b0);
        chk("rst_led",  sif.led,  8'hFF);

        resetn = 1'b0;
        @(negedge clk);
        chk("led_first", sif.led, 8'hFC);

        // 1: loop over 2..4
        push(4'd3, 1'b0); push(4'd4, 1'b0); push(4'd2, 1'b0); push(4'd3, 1'b0);
        run_sb("loop");

        // 2: one-shot over 0..2, then hold in DONE
        sif.mode = ONESHOT; sif.start_addr = 4'd0; sif.end_addr = 4'd2;
        restart_pulse();
        chk("os_start_pc", sif.pc, 4'd0);
        push(4'd1, 1'b0); push(4'd2, 1'b0);
        for (int i = 0; i < 6; i++) push(4'd2, 1'b1);
        run_sb("oneshot");
        restart_pulse();
        chk("rs_pc",   sif.pc,   4'd0);
        chk("rs_done", sif.done, 1'b0);

        // 3: ping-pong over 1..3, then single-entry window at 5
        sif.mode = PINGPONG; sif.start_addr = 4'd1; sif.end_addr = 4'd3;
        restart_pulse();
        chk("pp_start_pc", sif.pc, 4'd1);
        push(4'd2, 1'b0); push(4'd3, 1'b0); push(4'd2, 1'b0); push(4'd1, 1'b0); push(4'd2, 1'b0);
        run_sb("ppong");
        sif.start_addr = 4'd5; sif.end_addr = 4'd5;
        for (int i = 0; i < 4; i++) push(4'd5, 1'b0);
        run_sb("ppone");

        // 4: pause mid-count
        sif.mode = LOOP; sif.start_addr = 4'd0; sif.end_addr = 4'd15;
        restart_pulse();
        push(4'd1, 1'b0);
        run_sb("prepause");
        repeat (2) @(negedge clk);
        sif.pause = 1'b1;
        nsteps = 0;
        repeat (20) begin
            @(negedge clk);
            if (sif.step === 1'b1) nsteps++;
        end
        chk("pause_steps", nsteps, 0);
        chk("pause_pc", sif.pc, 4'd1);
        rel = cyc;
        sif.pause = 1'b0;
        wait_step(at);
        chk("pause_resume", at - rel, 4);
        chk("pause_next_pc", sif.pc, 4'd2);

        // 5: write the displayed entry
        @(negedge clk);
        chk("wr_before", sif.led, 8'hFC);
        sif.wr_en = 1'b1; sif.wr_addr = 4'd2; sif.wr_data = 8'hA5;
        @(negedge clk);
        sif.wr_en = 1'b0;
        mdl[2] = 8'hA5;
        chk("wr_same", sif.led, 8'hFC);
        @(negedge clk);
        chk("wr_next", sif.led, 8'h5A);

        // enter DONE, then reset mid-run
        sif.mode = ONESHOT; sif.start_addr = 4'd0; sif.end_addr = 4'd2;
        push(4'd2, 1'b1);
        run_sb("os2");
        sif.mode = LOOP; sif.start_addr = 4'd6; sif.end_addr = 4'd9;
        resetn = 1'b1;
        @(negedge clk);
        chk("mr_led",  sif.led,  8'hFF);
        chk("mr_pc",   sif.pc,   4'd6);
        chk("mr_done", sif.done, 1'b0);
        resetn = 1'b0;
        push(4'd7, 1'b0);
        run_sb("postrst");

        // inverted window collapses to start
        sif.start_addr = 4'd12; sif.end_addr = 4'd10;
        push(4'd12, 1'b0); push(4'd12, 1'b0);
        run_sb("badwin");

`ifdef LED_SEQ_PWM_EN
        // 6: brightness gating
        sif.start_addr = 4'd0; sif.end_addr = 4'd0;
        sif.wr_en = 1'b1; sif.wr_addr = 4'd0; sif.wr_data = 8'h01;
        mdl[0] = 8'h01;
        @(negedge clk);
        sif.wr_en = 1'b0;
        sif.brightness = 4'd4;
        restart_pulse();
        repeat (2) @(negedge clk);
        nsteps = 0;
        repeat (32) begin
            @(negedge clk);
            if (sif.led[0] === 1'b0) nsteps++;
        end
        chk("pwm_b4", nsteps, 8);
        sif.brightness = 4'hF;
        repeat (2) @(negedge clk);
        nsteps = 0;
        repeat (32) begin
            @(negedge clk);
            if (sif.led[0] === 1'b0) nsteps++;
        end
        chk("pwm_b15", nsteps, 32);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
